// File: rtl/serial_link_pkg.sv
// Shared state type and frame-length helper for the serial bank link.
// Defining PARITY_EN adds one even-parity bit to every frame.
package serial_link_pkg;

`ifdef PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StGap,
    StWait,
    StRshift,
    StWrite,
    StDone
  } state_e;

  function automatic int unsigned frame_len(input int unsigned aw, input int unsigned dw);
    return aw + dw + PAR_BITS;
  endfunction

endpackage

// File: rtl/serial_bank_link_if.sv
// Control and register-bank signals of one serial bank link instance.
// master: the link itself; slave: the bank / controller side.
interface serial_bank_link_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 5
);
  logic          start;
  logic          updown;
  logic          done;
  logic          err;
  logic          RB1_RW;
  logic [AW-1:0] RB1_A;
  logic [DW-1:0] RB1_D;
  logic [DW-1:0] RB1_Q;

  modport master (
    input  start, updown, RB1_Q,
    output done, err, RB1_RW, RB1_A, RB1_D
  );

  modport slave (
    output start, updown, RB1_Q,
    input  done, err, RB1_RW, RB1_A, RB1_D
  );
endinterface

// File: rtl/link_shreg.sv
// Frame shift register with bit counter, shared by transmit and receive.
// Bits leave at the MSB and enter at the LSB on the same shift operation.
module link_shreg #(
  parameter int unsigned Width = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             first,
  input  logic             sin,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] data,
  output logic             msb,
  output logic             last_bit
);
  localparam int unsigned CW = $clog2(Width + 1);

  logic [Width-1:0] data_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= load_val;
      cnt_q  <= '0;
    end else if (shift) begin
      data_q <= {data_q[Width-2:0], sin};
      // first restarts the count at the opening bit of a received frame
      cnt_q  <= first ? CW'(1) : cnt_q + CW'(1);
    end
  end

  assign data     = data_q;
  assign msb      = data_q[Width-1];
  assign last_bit = (cnt_q == CW'(Width - 1));

endmodule

// File: rtl/serial_bank_link.sv
// Serial bank link: moves NWORDS bank words over a two-wire sen/sd link in either direction.
// Optional PARITY_EN appends and checks an even-parity bit per frame.
module serial_bank_link
  import serial_link_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 5,
  parameter int unsigned NWORDS = 18
) (
  input  logic               clk,
  input  logic               rst,
  serial_bank_link_if.master bus,
  inout  wire                sen,
  inout  wire                sd
);
  localparam int unsigned FL  = frame_len(AW, DW);
  localparam int unsigned WCW = $clog2(NWORDS + 1);

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           done_q, done_d;
  logic           drive_q;
  logic           start_ok, sen_low, frame_ok, wr_en;
  logic           sr_load, sr_shift, sr_first, sr_in, sr_msb, sr_last;
  logic [FL-1:0]  sr_data, sr_load_val;

  assign sen_low  = (sen == 1'b0);
  assign start_ok = bus.start && ((state_q == StIdle) || (state_q == StDone));

`ifdef PARITY_EN
  assign sr_load_val = {addr_q, bus.RB1_Q, ^{addr_q, bus.RB1_Q}};
  assign frame_ok    = ~^sr_data;
`else
  assign sr_load_val = {addr_q, bus.RB1_Q};
  assign frame_ok    = 1'b1;
`endif

  link_shreg #(
    .Width(FL)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (sr_load),
    .shift   (sr_shift),
    .first   (sr_first),
    .sin     (sr_in),
    .load_val(sr_load_val),
    .data    (sr_data),
    .msb     (sr_msb),
    .last_bit(sr_last)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wcnt_d   = wcnt_q;
    done_d   = done_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_first = 1'b0;
    sr_in    = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_ok) begin
          done_d  = 1'b0;
          addr_d  = AW'(NWORDS - 1);
          wcnt_d  = '0;
          state_d = bus.updown ? StWait : StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        sr_load = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        sr_shift = 1'b1;
        if (sr_last) state_d = StGap;
      end
      StGap: begin
        if (addr_q == '0) begin
          state_d = StDone;
        end else begin
          addr_d  = addr_q - AW'(1);
          state_d = StFetch;
        end
      end
      StWait: begin
        if (sen_low) begin
          sr_shift = 1'b1;
          sr_first = 1'b1;
          sr_in    = sd;
          state_d  = StRshift;
        end
      end
      StRshift: begin
        if (sen_low) begin
          sr_shift = 1'b1;
          sr_in    = sd;
          if (sr_last) state_d = StWrite;
        end else begin
          state_d = StWait;
        end
      end
      StWrite: begin
        wr_en = frame_ok;
        if (frame_ok) wcnt_d = wcnt_q + WCW'(1);
        // A frame whose sen falls during the write cycle starts shifting immediately
        if (wcnt_d == WCW'(NWORDS)) begin
          state_d = StDone;
        end else if (sen_low) begin
          sr_shift = 1'b1;
          sr_first = 1'b1;
          sr_in    = sd;
          state_d  = StRshift;
        end else begin
          state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StDone) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      drive_q <= (state_d == StShift);
    end
  end

`ifdef PARITY_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if ((state_q == StWrite) && !frame_ok) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.done   = done_q;
  assign bus.RB1_RW = ~wr_en;
  assign bus.RB1_A  = (state_q == StWrite) ? sr_data[FL-1 -: AW] : addr_q;
  assign bus.RB1_D  = (state_q == StWrite) ? sr_data[FL-1-AW -: DW] : '0;

  assign sen = drive_q ? 1'b0 : 1'bz;
  assign sd  = drive_q ? sr_msb : 1'bz;

endmodule

// File: tb/tb_serial_bank_link.sv
// Bench for serial_bank_link: directed and randomised transmit/receive runs against a frame model.
// Covers the PARITY_EN build as well when that macro is defined.
module tb_serial_bank_link;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NW = 18;
`ifdef PARITY_EN
  localparam int FL = AW + DW + 1;
  localparam logic [31:0] ADDR5_FRAME = 32'h0000_0B4A;
`else
  localparam int FL = AW + DW;
  localparam logic [31:0] ADDR5_FRAME = 32'h0000_05A5;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_oe = 1'b0;
  logic tb_sd = 1'b0;
  wire  sen;
  wire  sd;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sen = tb_oe ? 1'b0 : 1'bz;
  assign sd  = tb_oe ? tb_sd : 1'bz;
  pullup (sen);
  pullup (sd);

  serial_bank_link_if #(.DW(DW), .AW(AW)) bus ();

  serial_bank_link #(
    .DW    (DW),
    .AW    (AW),
    .NWORDS(NW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .sen(sen),
    .sd (sd)
  );

  logic [7:0] bank [32];
  always @(posedge clk) bus.RB1_Q <= bank[bus.RB1_A];

  // Link and bank monitor: collects every sen-low burst and every write strobe.
  logic        in_frame = 1'b0;
  int          flen = 0;
  int          fstart = 0;
  logic [31:0] fbits = '0;
  logic [31:0] fq_bits[$];
  int          fq_len[$];
  int          fq_start[$];
  int          wq_a[$];
  int          wq_d[$];
  int          wq_cyc[$];

  always @(negedge clk) begin
    if (sen === 1'b0) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        fbits    = '0;
        flen     = 0;
        fstart   = cyc;
      end
      fbits = {fbits[30:0], sd};
      flen++;
    end else if (in_frame) begin
      in_frame = 1'b0;
      fq_bits.push_back(fbits);
      fq_len.push_back(flen);
      fq_start.push_back(fstart);
    end
    if (bus.RB1_RW === 1'b0) begin
      wq_a.push_back(int'(bus.RB1_A));
      wq_d.push_back(int'(bus.RB1_D));
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_frame(input logic [4:0] a, input logic [7:0] d);
`ifdef PARITY_EN
    return {18'b0, a, d, ^{a, d}};
`else
    return {19'b0, a, d};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tb_oe = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start(input logic ud, output int t0);
    t0         = cyc;
    bus.updown = ud;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1) begin
        t = cyc;
        break;
      end
      step();
    end
  endtask

  // Drives the first nbits of a FL-bit frame, MSB first; lb is the cycle of the last bit.
  task automatic drive(input logic [31:0] f, input int nbits, output int lb);
    lb = cyc;
    for (int i = FL - 1; i >= FL - nbits; i--) begin
      tb_oe = 1'b1;
      tb_sd = f[i];
      lb    = cyc;
      step();
    end
  endtask

  task automatic tx_run(input string tag, input bit poke);
    int t0, td, fb, a;
    fb = fq_bits.size();
    pulse_start(1'b0, t0);
    if (poke) begin
      repeat (40) step();
      bus.updown = 1'b1;
      bus.start  = 1'b1;
      step();
      bus.start  = 1'b0;
    end
    wait_done(700, td);
    check({tag, "_done_lat"}, td - t0, NW * (FL + 3) + 1);
    step();
    check({tag, "_nframes"}, fq_bits.size() - fb, NW);
    check({tag, "_first_start"}, fq_start[fb] - t0, 3);
    for (int k = 0; k < NW && fb + k < fq_bits.size(); k++) begin
      a = NW - 1 - k;
      check($sformatf("%s_frame%0d", tag, a), fq_bits[fb + k], mk_frame(5'(a), bank[a]));
      check($sformatf("%s_len%0d", tag, a), fq_len[fb + k], FL);
      if (k > 0) begin
        check($sformatf("%s_spacing%0d", tag, a), fq_start[fb + k] - fq_start[fb + k - 1], FL + 3);
      end
    end
  endtask

  task automatic rx_run(input string tag, input bit rnd);
    int t0, lb, fw, n;
    logic [4:0] a;
    logic [7:0] d;
    int ea[$], ed[$], ec[$];
    fw = wq_a.size();
    pulse_start(1'b1, t0);
    idle(2);
    for (int k = 0; k < NW; k++) begin
      a = rnd ? 5'($urandom_range(0, 31)) : 5'(k);
      d = rnd ? 8'($urandom_range(0, 255)) : ((k == 2) ? 8'h55 : (8'h3C ^ 8'(k)));
      if (rnd ? ($urandom_range(0, 3) == 0) : (k == 2)) begin
        n = rnd ? $urandom_range(1, FL - 1) : 7;
        drive($urandom, n, lb);
        idle(rnd ? $urandom_range(1, 2) : 1);
      end
      drive(mk_frame(a, d), FL, lb);
      ea.push_back(int'(a));
      ed.push_back(int'(d));
      ec.push_back(lb + 1);
      if (k == NW - 1) begin
        tb_oe = 1'b0;
        check({tag, "_done_early"}, bus.done, 0);
        step();
        check({tag, "_done"}, bus.done, 1);
      end else begin
        idle(rnd ? $urandom_range(0, 2) : ((k == 10) ? 0 : 1));
      end
    end
    idle(3);
    check({tag, "_nwrites"}, wq_a.size() - fw, NW);
    for (int i = 0; i < NW && fw + i < wq_a.size(); i++) begin
      check($sformatf("%s_wa%0d", tag, i), wq_a[fw + i], ea[i]);
      check($sformatf("%s_wd%0d", tag, i), wq_d[fw + i], ed[i]);
      check($sformatf("%s_wcyc%0d", tag, i), wq_cyc[fw + i], ec[i]);
    end
  endtask

`ifdef PARITY_EN
  task automatic parity_run();
    int t0, lb, fw;
    int ea[$], ed[$];
    fw = wq_a.size();
    pulse_start(1'b1, t0);
    idle(2);
    for (int k = 0; k < NW; k++) begin
      if (k == 9) begin
        drive(mk_frame(5'(k), 8'h3C ^ 8'(k)) ^ 32'h1, FL, lb);
        idle(2);
        check("par_err_set", bus.err, 1);
      end
      drive(mk_frame(5'(k), 8'h3C ^ 8'(k)), FL, lb);
      ea.push_back(k);
      ed.push_back(int'(8'h3C ^ 8'(k)));
      idle(1);
    end
    idle(3);
    check("par_done", bus.done, 1);
    check("par_err_sticky", bus.err, 1);
    check("par_nwrites", wq_a.size() - fw, NW);
    for (int i = 0; i < NW && fw + i < wq_a.size(); i++) begin
      check($sformatf("par_wa%0d", i), wq_a[fw + i], ea[i]);
      check($sformatf("par_wd%0d", i), wq_d[fw + i], ed[i]);
    end
    pulse_start(1'b0, t0);
    check("par_err_clr", bus.err, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(2);
  endtask
`endif

  initial begin
    int t0, fb;
    bus.start  = 1'b0;
    bus.updown = 1'b0;
    for (int k = 0; k < 32; k++) bank[k] = 8'hA0 + 8'(k);

    repeat (3) step();
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_rw", bus.RB1_RW, 1);
    check("rst_a", bus.RB1_A, 0);
    check("rst_d", bus.RB1_D, 0);
    check("rst_sen", sen, 1);
    check("rst_sd", sd, 1);

    // start coinciding with the last reset cycle is lost
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (4) step();
    check("start_with_rst_a", bus.RB1_A, 0);
    check("start_with_rst_frames", fq_bits.size(), 0);
    check("start_with_rst_sen", sen, 1);

    fb = fq_bits.size();
    tx_run("tx_fixed", 1'b0);
    check("tx_addr5_bits", fq_bits[fb + 12], ADDR5_FRAME);

    for (int k = 0; k < 32; k++) bank[k] = 8'($urandom);
    tx_run("tx_rand", 1'b1);
    check("tx_err", bus.err, 0);

    rx_run("rx_fixed", 1'b0);
    check("rx_err", bus.err, 0);
    rx_run("rx_rand", 1'b1);

`ifdef PARITY_EN
    parity_run();
`endif

    for (int k = 0; k < 32; k++) bank[k] = 8'hA0 + 8'(k);
    fb = fq_bits.size();
    pulse_start(1'b0, t0);
    for (int i = 0; i < 40 && !(in_frame && flen == 6); i++) step();
    check("rst_mid_reach", flen, 6);
    check("rst_mid_bit6", sd, 0);
    rst = 1'b1;
    step();
    check("rst_mid_sen", sen, 1);
    check("rst_mid_sd", sd, 1);
    check("rst_mid_rw", bus.RB1_RW, 1);
    check("rst_mid_done", bus.done, 0);
    rst = 1'b0;
    repeat (60) step();
    check("rst_mid_frames", fq_bits.size() - fb, 1);
    check("rst_mid_bits", fq_bits[fb], 32'h46);
    check("rst_mid_len", fq_len[fb], 7);
    check("rst_mid_idle", in_frame, 0);
    check("rst_mid_done_after", bus.done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bank_link.md
Name: serial_bank_link

Overview:
- Parametrised successor to the single-direction serial bank mover used in the register-bank transfer subsystem.
- One instance sits beside each register bank. It either transmits NWORDS bank words over a shared two-wire link, or receives frames from the link and writes them into its bank. Direction is selected per run by `updown`.
- Each frame carries the word address followed by the data, so the receiver needs no local address counter.

Parameters:
- DW, 8, data word width in bits.
- AW, 5, bank address width; also the width of the address field in each frame.
- NWORDS, 18, words per run; must be ≤ 2**AW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy.
- updown  in  1  sampled at start: 0 = transmit, 1 = receive.
- done  out  1  high from the end of a run until the next accepted start.
- err  out  1  sticky parity-error flag; cleared on start or rst.
- RB1_RW  out  1  bank strobe: 1 = read, 0 = write.
- RB1_A  out  AW  bank address.
- RB1_D  out  DW  bank write data.
- RB1_Q  in  DW  bank read data, valid the cycle after RB1_A is presented.
- sen  inout  1  frame enable, active low; released to z when not driving.
- sd  inout  1  serial data; released to z when not driving.

Behaviour:
- **Clock and reset.** One clock. Reset is synchronous and active-high, on rst.
- **Reset values.**
  - done=0, err=0, RB1_RW=1, RB1_A=0, RB1_D=0.
  - sen and sd are z from the reset edge onward.
  - All state goes to IDLE; rst aborts any frame in flight with no bank write.
- **Frame format.** FL = AW+DW bits, plus 1 with PARITY_EN.
  - Transmitter holds sen=0 for exactly FL consecutive cycles.
  - sd carries the address MSB-first, then the data MSB-first.
  - After each frame, sen is released for at least 1 cycle.
  - sen reads as z or 1 means idle.
- **Transmit FSM:** IDLE → FETCH → LOAD → SHIFT → GAP → (FETCH | DONE).
  - The address counter starts at NWORDS-1 and decrements to 0.
  - FETCH: drive RB1_A=addr, RB1_RW=1.
  - LOAD: capture {addr, RB1_Q} into the shift register.
  - SHIFT: drive sen=0 and sd=shreg MSB for FL cycles, using a bit counter 0..FL-1.
  - GAP: release the bus for 1 cycle. If addr==0, go to DONE; otherwise decrement addr and go to FETCH.
  - DONE: done=1, return to IDLE.
- **Receive FSM:** IDLE → WAIT → RSHIFT → WRITE → (WAIT | DONE). The bus is never driven in receive mode.
  - WAIT: on the first cycle with sen==0, shift in sd and enter RSHIFT with bit count 1.
  - RSHIFT: while sen==0, shift sd into the LSB. If sen goes high before FL bits, discard the frame, go back to WAIT, and do not count it.
  - WRITE: entered on the cycle after the FL-th bit. Drive RB1_RW=0, RB1_A=received addr, RB1_D=received data for exactly 1 cycle, then increment the word counter. Go to DONE when the count reaches NWORDS, otherwise to WAIT.
  - A sen low that begins during WRITE is sampled as the start of the next frame; no bits are lost.
- **Receive timing.** Latency from the last frame bit to the write strobe is 1 cycle.
- **Transmit timing.** One word takes FL+3 cycles; the full run takes NWORDS·(FL+3)+1 cycles from start to done.
- **Bus drive.** sen and sd are driven only from registered enables, never combinationally from inputs.
- **Start handling.** start arriving together with rst is lost, because rst wins. start while not IDLE or DONE is ignored.

Optional Feature:
- Macro PARITY_EN.
- **Defined:**
  - The transmitter appends one even-parity bit, computed over address and data, after the data LSB, so FL = AW+DW+1.
  - The receiver checks parity. On mismatch it suppresses the WRITE strobe, sets err=1, and does not count the frame toward NWORDS.
- **Undefined:**
  - FL = AW+DW.
  - err is tied to 0.

Decomposition:
- **Package serial_link_pkg:**
  - state enum (IDLE, FETCH, LOAD, SHIFT, GAP, WAIT, RSHIFT, WRITE, DONE);
  - constant function frame_len(AW, DW);
  - localparam PAR_BITS, conditional on PARITY_EN.
- **Sub-module link_shreg:**
  - FL-wide shift register with load, shift_out (MSB) and shift_in (LSB) controls;
  - bit counter and last_bit flag;
  - shared by both directions.
- **Top-level:** the FSM, word and address counters, bank interface, and tri-state drivers.

Test Plan:
- Reset mid-frame: assert rst at bit 6 of a transmit frame → sen and sd are z and RB1_RW=1 on the next cycle, done=0, and no further frames are sent.
- Transmit, updown=0, bank[k]=8'hA0+k → 18 frames with addresses 17..0. The frame at addr 5 shows the serial bits 00101_10100101. Each frame is 13 sen-low cycles with a 3-cycle spacing of 2 idle + 1 fetch; done rises 289 cycles after start.
- Receive, updown=1: drive 18 frames {addr=k, data=8'h3C^k} → 18 one-cycle RB1_RW=0 strobes, each 1 cycle after the last bit, with matching A/D; done rises after the 18th write.
- Truncated frame: raise sen after 7 bits, then send a full frame (addr 2, data 8'h55) → exactly one write, to addr 2 with 8'h55.
- Back-to-back receive: the next frame's sen falls during the WRITE cycle → both words are written correctly.
- PARITY_EN: flip the parity bit of the frame for addr 9 → no write to addr 9, err=1 (sticky). A resent correct frame is then written, and err stays 1 until the next start.
